des_cbc_dec: RTL and testbench
==============================

DES_CBC_DEC -- requirements
Module: des_cbc_dec

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FIFO_DEPTH, 32, chain-FIFO entries; must exceed DES_Dec latency plus 1.
- BLK_W, 64, DES block width; fixed.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on its rising edge.
- rstn, in, 1, reset; synchronous and active-low.
- key, in, 64, DES key; stable while any block is in flight.
- iv, in, 64, initialisation vector.
- iv_load, in, 1, one-cycle strobe; starts a new chain with iv.
- cipher, in, 64, ciphertext block.
- cipher_en, in, 1, one-cycle strobe; cipher valid.
- plain, out, 64, recovered plaintext.
- plain_rdy, out, 1, one-cycle strobe; plain valid.
- err, out, 1, sticky protocol error flag.
- busy, out, 1, high while any block is in flight.

Function
REQ-003 Output SHALL be CBC decryption: plain_i = DES_Dec(cipher_i, key) XOR cipher_(i-1), with cipher_0 = iv.
REQ-004 FSM states SHALL be IDLE (no chain), RUN (chain active) and FAULT (err set).
- IDLE to RUN on iv_load.
- RUN to RUN on iv_load (chain restart).
- IDLE or RUN to FAULT on any error condition.
- FAULT exits only on reset.
REQ-005 In RUN, on cipher_en the block SHALL:
- pass cipher and key to the DES_Dec core the same cycle;
- push the previous-cipher register into the chain FIFO;
- load the previous-cipher register with cipher.
REQ-006 On iv_load, the block SHALL load the previous-cipher register with iv.
REQ-007 When iv_load and cipher_en coincide, the block SHALL:
- push iv into the chain FIFO;
- load the previous-cipher register with cipher.
The current block is thus the first block of the new chain.
REQ-008 On core plain_rdy, the block SHALL pop the FIFO head and register core_plain XOR head into plain.
REQ-009 plain_rdy SHALL pulse exactly one cycle after core plain_rdy. Total latency SHALL be DES_Dec latency plus 1 cycle.
REQ-010 The block SHALL accept cipher_en on every cycle, back-to-back, with no backpressure. Output order SHALL equal input order.
REQ-011 A simultaneous push and pop SHALL leave the FIFO occupancy unchanged. This SHALL be legal at occupancy 0 and at occupancy FIFO_DEPTH.
REQ-012 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be held in a log2(FIFO_DEPTH)+1-bit counter.
REQ-013 Each of the following SHALL set err and enter FAULT:
- cipher_en in IDLE (the block is not forwarded to the core);
- a push with the FIFO full and no simultaneous pop;
- a core plain_rdy with the FIFO empty.
REQ-014 In FAULT, the block SHALL ignore cipher_en and iv_load and hold plain_rdy low.
REQ-015 busy SHALL equal (FIFO occupancy != 0).

Reset
REQ-016 While rstn is low at a clk edge, the block SHALL set:
- plain=0, plain_rdy=0, err=0, busy=0;
- state=IDLE;
- FIFO empty, pointers 0;
- previous-cipher register 0.
REQ-017 A reset asserted mid-stream SHALL discard all in-flight blocks. No plain_rdy SHALL occur for those blocks after reset releases.
REQ-018 The block SHALL hold the DES_Dec core in reset via the same rstn.

Structure
REQ-019 A shared package des_pkg SHALL hold:
- BLK_W=64;
- DES_DEC_LAT (DES_Dec latency in cycles);
- the FSM state enum (IDLE, RUN, FAULT).
REQ-020 The chain FIFO SHALL be one sub-module, des_chain_fifo, with:
- synchronous push, pop, full, empty and count;
- storage without reset.
REQ-021 The block SHALL instantiate the existing DES_Dec unmodified. DES_Dec port mapping is cipher_en in, plain_rdy out.
REQ-022 An elaboration check SHALL fail if FIFO_DEPTH <= DES_DEC_LAT+1.

Verification
REQ-023 Single block, IV=0: key=133457799BBCDFF1, iv=0000000000000000, cipher=85E813540F0AB405. Required: plain=0123456789ABCDEF, with plain_rdy DES_DEC_LAT+1 cycles after cipher_en.
REQ-024 Nonzero IV: iv=FFFFFFFFFFFFFFFF, same key and cipher. Required: plain=FEDCBA9876543210.
REQ-025 Chaining: iv=0, then cipher_en on 3 consecutive cycles (ciphertexts from a reference CBC encryption of 3 blocks). Required:
- 3 back-to-back plain_rdy pulses with the correct plaintexts;
- busy falls after the third.
REQ-026 Simultaneous events: iv_load together with the second of 2 blocks. Required: block 2 plaintext is XORed with the new iv, not with cipher_1.
REQ-027 Error cases:
- cipher_en before any iv_load. Required: err=1, state FAULT, no plain_rdy.
- Reset asserted with 5 blocks in flight. Required: no plain_rdy afterwards; all outputs 0.
REQ-028 Stress: cipher_en every cycle for 200 blocks. Required:
- 200 correct outputs in order;
- err stays 0;
- peak occupancy <= DES_DEC_LAT+1.

Source files
------------

// File: rtl/des_pkg.sv
// Shared definitions for the DES-CBC decryption block.
package des_pkg;
   localparam int BLK_W       = 64;
   localparam int DES_DEC_LAT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_e;
endpackage

// File: rtl/DES_Dec.sv
// Fully pipelined DES decryption core, one Feistel round per stage (16 cycles).
module DES_Dec (
   input  logic        clk,
   input  logic        rstn,
   input  logic [63:0] key,
   input  logic [63:0] cipher,
   input  logic        cipher_en,
   output logic [63:0] plain,
   output logic        plain_rdy
);
   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                               16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                 41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   // cumulative left-rotation of C/D after each round
   localparam int ROT_T [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};
   localparam int SB [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   // Table entries use DES bit numbering: bit 1 is the MSB.
   function automatic logic [63:0] ip_f(input logic [63:0] x);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [63:0] fp_f(input logic [63:0] x);
      logic [63:0] o;
      o = '0;
      for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [47:0] e_f(input logic [31:0] x);
      logic [47:0] o;
      o = '0;
      for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [31:0] p_f(input logic [31:0] x);
      logic [31:0] o;
      o = '0;
      for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
      return o;
   endfunction

   function automatic logic [55:0] pc1_f(input logic [63:0] x);
      logic [55:0] o;
      o = '0;
      for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [47:0] pc2_f(input logic [55:0] x);
      logic [47:0] o;
      o = '0;
      for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
      return o;
   endfunction

   function automatic logic [3:0] sbox_f(input int n, input logic [5:0] b);
      int idx;
      idx = n * 64 + 16 * int'({b[5], b[0]}) + int'(b[4:1]);
      return 4'(SB[9'(idx)]);
   endfunction

   function automatic logic [47:0] subkey_f(input logic [63:0] k, input int rnd);
      logic [55:0] cd, tc, td;
      cd = pc1_f(k);
      tc = {cd[55:28], cd[55:28]} << ROT_T[4'(rnd)];
      td = {cd[27:0], cd[27:0]} << ROT_T[4'(rnd)];
      return pc2_f({tc[55:28], td[55:28]});
   endfunction

   function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [31:0] s;
      x = e_f(r) ^ k;
      s = '0;
      for (int n = 0; n < 8; n++) s[5'(31 - 4 * n) -: 4] = sbox_f(n, x[6'(47 - 6 * n) -: 6]);
      return p_f(s);
   endfunction

   logic [47:0] sk [16];
   logic [63:0] lr_d [16];
   logic [63:0] lr_q [16];
   logic [15:0] vld_q;
   logic [15:0] vld_d;

   always_comb begin
      logic [63:0] st;
      for (int i = 0; i < 16; i++) begin
         sk[4'(i)] = subkey_f(key, i);
      end
      // decryption walks the subkeys in reverse order: stage 0 uses K16
      for (int i = 0; i < 16; i++) begin
         st = (i == 0) ? ip_f(cipher) : lr_q[4'(i - 1)];
         lr_d[4'(i)] = {st[31:0], st[63:32] ^ feistel_f(st[31:0], sk[4'(15 - i)])};
      end
      vld_d = {vld_q[14:0], cipher_en};
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 16; i++) lr_q[4'(i)] <= lr_d[4'(i)];
   end

   always_ff @(posedge clk) begin
      if (!rstn) vld_q <= '0;
      else       vld_q <= vld_d;
   end

   assign plain     = fp_f({lr_q[15][31:0], lr_q[15][63:32]});
   assign plain_rdy = vld_q[15];
endmodule

// File: rtl/des_chain_fifo.sv
// Chain FIFO holding the previous-cipher value for each block in the core.
module des_chain_fifo #(
   parameter  int DEPTH = 32,
   parameter  int W     = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= din;
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   // an empty FIFO pushed and popped together passes the new entry straight through
   assign dout  = empty ? din : mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/des_cbc_dec.sv
// DES-CBC decryption wrapper: chains DES_Dec output with the previous ciphertext.
//   state | meaning
//   IDLE  | no chain started, cipher_en is an error
//   RUN   | chain active, blocks accepted every cycle
//   FAULT | protocol error seen, inputs ignored until reset
module des_cbc_dec #(
   parameter int FIFO_DEPTH = 32,
   parameter int BLK_W      = 64
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [BLK_W-1:0] key,
   input  logic [BLK_W-1:0] iv,
   input  logic             iv_load,
   input  logic [BLK_W-1:0] cipher,
   input  logic             cipher_en,
   output logic [BLK_W-1:0] plain,
   output logic             plain_rdy,
   output logic             err,
   output logic             busy
);
   import des_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH <= DES_DEC_LAT + 1 || BLK_W != des_pkg::BLK_W) begin : g_bad_cfg
      $error("des_cbc_dec: FIFO_DEPTH must exceed DES_DEC_LAT+1 and BLK_W must be 64");
   end

   state_e           state_q, state_d;
   logic [BLK_W-1:0] prev_q, prev_d, plain_q, plain_d;
   logic             plain_rdy_q, plain_rdy_d, err_q, err_d;
   logic [BLK_W-1:0] push_data, fifo_head, core_plain;
   logic             push, pop, core_en, core_rdy, fifo_full, fifo_empty, bad;
   logic [CNT_W-1:0] fifo_count;

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      plain_d     = plain_q;
      plain_rdy_d = 1'b0;
      err_d       = err_q;
      push        = 1'b0;
      pop         = 1'b0;
      push_data   = prev_q;
      core_en     = 1'b0;
      bad         = 1'b0;
      if (state_q != FAULT) begin
         if (iv_load) begin
            prev_d  = iv;
            state_d = RUN;
         end
         if (cipher_en) begin
            if (state_q == RUN || iv_load) begin
               core_en   = 1'b1;
               push      = 1'b1;
               push_data = iv_load ? iv : prev_q;
               prev_d    = cipher;
            end else begin
               bad = 1'b1;
            end
         end
         if (core_rdy) begin
            if (fifo_empty) begin
               bad = 1'b1;
            end else begin
               pop         = 1'b1;
               plain_d     = core_plain ^ fifo_head;
               plain_rdy_d = 1'b1;
            end
         end
         if (push && fifo_full && !pop) bad = 1'b1;
         // an error cycle commits nothing except the move to FAULT
         if (bad) begin
            state_d     = FAULT;
            err_d       = 1'b1;
            core_en     = 1'b0;
            push        = 1'b0;
            pop         = 1'b0;
            plain_rdy_d = 1'b0;
            prev_d      = prev_q;
            plain_d     = plain_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         prev_q      <= '0;
         plain_q     <= '0;
         plain_rdy_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         plain_q     <= plain_d;
         plain_rdy_q <= plain_rdy_d;
         err_q       <= err_d;
      end
   end

   DES_Dec u_core (
      .clk       (clk),
      .rstn      (rstn),
      .key       (key),
      .cipher    (cipher),
      .cipher_en (core_en),
      .plain     (core_plain),
      .plain_rdy (core_rdy)
   );

   des_chain_fifo #(.DEPTH(FIFO_DEPTH), .W(BLK_W)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign plain     = plain_q;
   assign plain_rdy = plain_rdy_q;
   assign err       = err_q;
   assign busy      = (fifo_count != '0);
endmodule

// File: tb/tb_des_cbc_dec.sv
// Directed-vector bench for des_cbc_dec using the classic DES worked example.
module tb_des_cbc_dec;
   import des_pkg::*;

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
   localparam logic [63:0] CT  = 64'h85E813540F0AB405;
   localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
   // CT repeated is a valid CBC stream: later blocks decrypt to PT ^ CT
   localparam logic [63:0] PT_CHAIN = 64'h84CB563386A179EA;
   localparam logic [63:0] PT_IV1   = 64'hFEDCBA9876543210;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [63:0] key = KEY;
   logic [63:0] iv = '0;
   logic        iv_load = 1'b0;
   logic [63:0] cipher = '0;
   logic        cipher_en = 1'b0;
   logic [63:0] plain;
   logic        plain_rdy, err, busy;

   int n_checks = 0;
   int n_fail = 0;

   des_cbc_dec #(.FIFO_DEPTH(32), .BLK_W(64)) dut (
      .clk(clk), .rstn(rstn), .key(key), .iv(iv), .iv_load(iv_load),
      .cipher(cipher), .cipher_en(cipher_en), .plain(plain),
      .plain_rdy(plain_rdy), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; iv_load = 1'b0; cipher_en = 1'b0;
      step(); step();
      rstn = 1'b1;
   endtask

   task automatic wait_rdy(output int cyc);
      cyc = 0;
      while (!plain_rdy && cyc < 40) begin step(); cyc++; end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (plain !== 64'h0) begin n_fail++; $display("FAIL reset_plain: got %h want 0", plain); end
      n_checks++; if (plain_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", plain_rdy); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_single();
      int cyc;
      do_reset();
      iv = '0; iv_load = 1'b1; step(); iv_load = 1'b0;
      cipher = CT; cipher_en = 1'b1; step(); cipher_en = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
      cyc = 1;
      while (!plain_rdy && cyc < 40) begin step(); cyc++; end
      n_checks++; if (cyc !== DES_DEC_LAT + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", cyc, DES_DEC_LAT + 1); end
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT) begin n_fail++; $display("FAIL single_plain: got %h rdy %b want %h", plain, plain_rdy, PT); end
      step();
      n_checks++; if (plain_rdy !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got rdy %b busy %b want 0 0", plain_rdy, busy); end
   endtask

   task automatic test_nonzero_iv();
      int cyc;
      iv = '1; iv_load = 1'b1; step(); iv_load = 1'b0;
      cipher = CT; cipher_en = 1'b1; step(); cipher_en = 1'b0;
      wait_rdy(cyc);
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT_IV1) begin n_fail++; $display("FAIL nonzero_iv: got %h rdy %b want %h", plain, plain_rdy, PT_IV1); end
   endtask

   task automatic test_chaining();
      int cyc;
      do_reset();
      iv = '0; iv_load = 1'b1; step(); iv_load = 1'b0;
      cipher = CT; cipher_en = 1'b1;
      step(); step(); step();
      cipher_en = 1'b0;
      wait_rdy(cyc);
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT) begin n_fail++; $display("FAIL chain_b1: got %h rdy %b want %h", plain, plain_rdy, PT); end
      step();
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT_CHAIN) begin n_fail++; $display("FAIL chain_b2: got %h rdy %b want %h", plain, plain_rdy, PT_CHAIN); end
      step();
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT_CHAIN) begin n_fail++; $display("FAIL chain_b3: got %h rdy %b want %h", plain, plain_rdy, PT_CHAIN); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL chain_busy: got %b want 0", busy); end
      step();
      n_checks++; if (plain_rdy !== 1'b0) begin n_fail++; $display("FAIL chain_extra: got rdy %b want 0", plain_rdy); end
   endtask

   task automatic test_simultaneous();
      int cyc;
      do_reset();
      iv = '0; iv_load = 1'b1; step(); iv_load = 1'b0;
      cipher = CT; cipher_en = 1'b1; step();
      iv = '1; iv_load = 1'b1; step();
      iv_load = 1'b0; step();
      cipher_en = 1'b0;
      wait_rdy(cyc);
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT) begin n_fail++; $display("FAIL simul_b1: got %h rdy %b want %h", plain, plain_rdy, PT); end
      step();
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT_IV1) begin n_fail++; $display("FAIL simul_b2: got %h rdy %b want %h", plain, plain_rdy, PT_IV1); end
      step();
      n_checks++; if (plain_rdy !== 1'b1 || plain !== PT_CHAIN) begin n_fail++; $display("FAIL simul_b3: got %h rdy %b want %h", plain, plain_rdy, PT_CHAIN); end
   endtask

   task automatic test_err_idle();
      int pulses;
      do_reset();
      cipher = CT; cipher_en = 1'b1; step(); cipher_en = 1'b0;
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL idle_err: got %b want 1", err); end
      n_checks++; if (dut.state_q !== FAULT) begin n_fail++; $display("FAIL idle_state: got %0d want %0d", dut.state_q, FAULT); end
      iv = '0; iv_load = 1'b1; cipher_en = 1'b1; step();
      iv_load = 1'b0; step(); cipher_en = 1'b0;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin step(); if (plain_rdy) pulses++; end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL idle_rdy: got %0d pulses want 0", pulses); end
      n_checks++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_sticky: got err %b busy %b want 1 0", err, busy); end
   endtask

   task automatic test_reset_midstream();
      int pulses;
      do_reset();
      iv = '0; iv_load = 1'b1; step(); iv_load = 1'b0;
      cipher = CT; cipher_en = 1'b1;
      repeat (5) step();
      cipher_en = 1'b0;
      repeat (3) step();
      rstn = 1'b0; step(); step(); rstn = 1'b1;
      pulses = 0;
      for (int c = 0; c < 30; c++) begin step(); if (plain_rdy) pulses++; end
      n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_rdy: got %0d pulses want 0", pulses); end
      n_checks++; if (plain !== 64'h0 || err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_outs: got plain %h err %b busy %b want 0 0 0", plain, err, busy); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_q[$];
      logic [63:0] prev;
      int got, peak;
      do_reset();
      prev = '0; got = 0; peak = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               iv_load = (i % 4 == 0);
               iv = {32'hC0DE0000 | 32'(i), 32'(i) * 32'h01010101};
               exp_q.push_back(PT ^ (iv_load ? iv : prev));
               prev = CT;
               cipher = CT; cipher_en = 1'b1;
               step();
            end
            cipher_en = 1'b0; iv_load = 1'b0;
         end
         begin
            logic [63:0] e;
            for (int c = 0; c < 260 && got < 200; c++) begin
               step();
               if (int'(dut.u_fifo.count_q) > peak) peak = int'(dut.u_fifo.count_q);
               if (plain_rdy) begin
                  n_checks++;
                  if (exp_q.size() == 0) begin
                     n_fail++; $display("FAIL stress_extra: got %h with nothing expected", plain);
                  end else begin
                     e = exp_q.pop_front();
                     if (plain !== e) begin n_fail++; $display("FAIL stress_blk%0d: got %h want %h", got, plain, e); end
                  end
                  got++;
               end
            end
         end
      join
      n_checks++; if (got !== 200) begin n_fail++; $display("FAIL stress_count: got %0d want 200", got); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stress_err: got %b want 0", err); end
      n_checks++; if (peak > DES_DEC_LAT + 1 || peak == 0) begin n_fail++; $display("FAIL stress_peak: got %0d want 1..%0d", peak, DES_DEC_LAT + 1); end
      step();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stress_busy: got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_nonzero_iv();
      test_chaining();
      test_simultaneous();
      test_err_idle();
      test_reset_midstream();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
